// File: rtl/jk_mod_counter_pkg.sv
// Shared defaults and JK command encoding for the modulo counter.
package jk_mod_counter_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 10;

    // {J,K} command applied to each JK stage
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TOG  = 2'b11
    } jk_cmd_e;

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// Single JK flip-flop stage with synchronous active-high reset.
module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic J,
    input  logic K,
    output logic q
);

    logic q_q;

    // JK behaviour: hold, clear, set or toggle on each rising edge
    always_ff @(posedge clk) begin
        if (res) begin
            q_q <= 1'b0;
        end else begin
            case ({J, K})
                HOLD:    q_q <= q_q;
                CLR:     q_q <= 1'b0;
                SET:     q_q <= 1'b1;
                TOG:     q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo counter built from JK stages, with parallel load,
// combinational terminal count and a registered wrap pulse.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] j_bits;
    logic [WIDTH-1:0] k_bits;
    logic             wrap_q;
    logic             wrap_d;

    // Next count: reset > load (clamped) > count in the selected direction
    always_comb begin
        cnt_d = cnt_q;
        if (res) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (32'(din) >= MODULUS) ? TOP : din;
        end else if (en) begin
            if (up) begin
                cnt_d = (cnt_q == TOP) ? '0 : cnt_q + ONE;
            end else begin
                cnt_d = (cnt_q == '0) ? TOP : cnt_q - ONE;
            end
        end
    end

    // Terminal count: the coming edge will wrap the counter
    always_comb begin
        tc = en & ~load & ~res &
             ((up & (cnt_q == TOP)) | (~up & (cnt_q == '0)));
    end

    // JK excitation derived from current and next count
    always_comb begin
        j_bits = cnt_d & ~cnt_q;
        k_bits = ~cnt_d & cnt_q;
        wrap_d = tc;
    end

    // Wrap pulse register, one cycle after a terminal-count edge
    always_ff @(posedge clk) begin
        if (res) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cell u_cell (
            .clk (clk),
            .res (res),
            .J   (j_bits[i]),
            .K   (k_bits[i]),
            .q   (cnt_q[i])
        );
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Randomised and directed bench for jk_mod_counter: a default (4-bit, mod 10)
// instance and a power-of-two (3-bit, mod 8) instance share the controls and
// are each compared against an arithmetic modulo-counter model.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din_a = '0;
    logic [2:0] din_b = '0;
    logic [3:0] q_a;
    logic [2:0] q_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // model state
    int unsigned mq_a = 0, mq_b = 0;
    int unsigned mwrap_a = 0, mwrap_b = 0;

    always #5 clk = ~clk;

    jk_mod_counter u_dut_a (
        .clk (clk), .res (res), .en (en), .up (up), .load (load),
        .din (din_a), .q (q_a), .tc (tc_a), .wrap (wrap_a)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut_b (
        .clk (clk), .res (res), .en (en), .up (up), .load (load),
        .din (din_b), .q (q_b), .tc (tc_b), .wrap (wrap_b)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_next(input int unsigned cur, input int unsigned m,
                                               input bit r, input bit l, input bit e,
                                               input bit u, input int unsigned d);
        if (r) return 0;
        if (l) return (d >= m) ? m - 1 : d;
        if (e) return u ? (cur + 1) % m : (cur + m - 1) % m;
        return cur;
    endfunction

    function automatic int unsigned model_tc(input int unsigned cur, input int unsigned m,
                                             input bit r, input bit l, input bit e, input bit u);
        if (r || l || !e) return 0;
        return (u ? (cur == m - 1) : (cur == 0)) ? 1 : 0;
    endfunction

    // One clock: drive after falling edge, check tc before the rising edge,
    // then check q and wrap just after it.
    task automatic step(input bit r, input bit l, input bit e, input bit u, input int unsigned d);
        int unsigned etc_a, etc_b;
        @(negedge clk);
        res = r; load = l; en = e; up = u;
        din_a = 4'(d);
        din_b = 3'(d);
        #1;
        etc_a = model_tc(mq_a, 10, r, l, e, u);
        etc_b = model_tc(mq_b, 8, r, l, e, u);
        check_eq("tc_a", tc_a, etc_a);
        check_eq("tc_b", tc_b, etc_b);
        @(posedge clk);
        #1;
        mq_a = model_next(mq_a, 10, r, l, e, u, int'(din_a));
        mq_b = model_next(mq_b, 8, r, l, e, u, int'(din_b));
        mwrap_a = etc_a;
        mwrap_b = etc_b;
        check_eq("q_a", q_a, mq_a);
        check_eq("wrap_a", wrap_a, mwrap_a);
        check_eq("q_b", q_b, mq_b);
        check_eq("wrap_b", wrap_b, mwrap_b);
    endtask

    initial begin
        // reset with en/up asserted, then first count
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        check_eq("rst_q", q_a, 0);
        step(0, 0, 1, 1, 0);
        check_eq("first_count", q_a, 1);

        // up-count wrap from 0 over 12 cycles
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
        check_eq("up12_q", q_a, 2);

        // down-count wrap from 0
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check_eq("down_wrap_q", q_a, 9);
        check_eq("down_wrap_pulse", wrap_a, 1);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0);

        // load clamp and load priority over en
        step(0, 1, 1, 1, 13);
        check_eq("clamp_q", q_a, 9);
        check_eq("clamp_wrap", wrap_a, 0);
        step(0, 1, 1, 1, 3);
        check_eq("load_prio_q", q_a, 3);

        // reset beats load mid-operation
        step(0, 1, 0, 0, 5);
        step(1, 1, 1, 1, 7);
        check_eq("rst_wins_q", q_a, 0);

        // direction flip every cycle from 5
        step(0, 1, 0, 0, 5);
        for (int i = 0; i < 4; i++) step(0, 0, 1, (i % 2) == 0, 0);
        check_eq("flip_q", q_a, 5);

        // power-of-two modulus: 7 -> 0 with wrap
        step(0, 1, 0, 0, 7);
        step(0, 0, 1, 1, 0);
        check_eq("pow2_q", q_b, 0);
        check_eq("pow2_wrap", wrap_b, 1);

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 4), ($urandom_range(99) < 12),
                 ($urandom_range(99) < 75), $urandom_range(1), $urandom_range(15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
